// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module      : alu_sequencer
//  Description : Control sequencer for a bus-based ALU datapath. Fetches an
//                instruction (T0..T2), then steps through operand read, ALU
//                execute and result write-back (T3..T5), emitting Moore
//                datapath strobes decoded from the state and the IR fields.
//                Optional macro ALU_SEQUENCER_WIDE_EN adds a T6 state that
//                writes the high half of a mul/div result to Ra+1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Run,
    input  logic                    MemReady,
    input  logic [DATA_WIDTH-1:0]   IR,
    output logic                    PCout,
    output logic                    MARin,
    output logic                    IncPC,
    output logic                    PCin,
    output logic                    Read,
    output logic                    MDRin,
    output logic                    MDRout,
    output logic                    IRin,
    output logic                    Yin,
    output logic                    Zin,
    output logic                    Zlowout,
    output logic                    Zhighout,
    output logic                    Cout,
    output logic [NUM_REGS-1:0]     Rin,
    output logic [NUM_REGS-1:0]     Rout,
    output logic [OPCODE_WIDTH-2:0] alu_op,
    output logic                    Busy,
    output logic                    Done
);

    localparam int RW    = $clog2(NUM_REGS);
    localparam int IMM_W = DATA_WIDTH - OPCODE_WIDTH - 3 * RW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
`ifdef ALU_SEQUENCER_WIDE_EN
    localparam logic [2:0] S_T6   = 3'd7;

    localparam logic [OPCODE_WIDTH-2:0] OP_MUL = (OPCODE_WIDTH-1)'(4'b1110);
    localparam logic [OPCODE_WIDTH-2:0] OP_DIV = (OPCODE_WIDTH-1)'(4'b1111);
`endif

    logic [2:0]              state;
    logic [2:0]              next_state;
    logic                    t1_wait;   // high on every T1 cycle after the first
    logic                    done_q;
    logic                    armed;     // low for the first edge after reset release

    logic [OPCODE_WIDTH-1:0] opc;
    logic [RW-1:0]           ra;
    logic [RW-1:0]           rb;
    logic [RW-1:0]           rc;
    logic                    imm_form;
    logic                    last_state;

    // The immediate is consumed by the datapath, not by the sequencer.
    logic                    unused_imm;

    assign opc        = IR[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign ra         = IR[DATA_WIDTH-OPCODE_WIDTH-1 -: RW];
    assign rb         = IR[DATA_WIDTH-OPCODE_WIDTH-RW-1 -: RW];
    assign rc         = IR[DATA_WIDTH-OPCODE_WIDTH-2*RW-1 -: RW];
    assign imm_form   = opc[OPCODE_WIDTH-1];
    assign unused_imm = ^IR[IMM_W-1:0];

`ifdef ALU_SEQUENCER_WIDE_EN
    logic          wide_op;
    logic [RW-1:0] ra_hi;

    // Double-width results only exist for the register form of mul/div.
    assign wide_op    = !imm_form &&
                        ((opc[OPCODE_WIDTH-2:0] == OP_MUL) ||
                         (opc[OPCODE_WIDTH-2:0] == OP_DIV));
    // RW-bit add wraps naturally, giving (Ra+1) mod NUM_REGS.
    assign ra_hi      = ra + RW'(1);
    assign last_state = (state == S_T6) || ((state == S_T5) && !wide_op);
`else
    assign last_state = (state == S_T5);
`endif

    // State register plus the small amount of bookkeeping state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            t1_wait <= 1'b0;
            done_q  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= next_state;
            t1_wait <= (state == S_T1) && !MemReady;
            done_q  <= last_state;
            armed   <= 1'b1;
        end
    end

    // Next-state decode; Run only matters in IDLE and the final state.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: next_state = (Run && armed) ? S_T0 : S_IDLE;
            S_T0:   next_state = S_T1;
            S_T1:   next_state = MemReady ? S_T2 : S_T1;
            S_T2:   next_state = S_T3;
            S_T3:   next_state = S_T4;
            S_T4:   next_state = S_T5;
`ifdef ALU_SEQUENCER_WIDE_EN
            S_T5: begin
                if (wide_op) begin
                    next_state = S_T6;
                end else begin
                    next_state = Run ? S_T0 : S_IDLE;
                end
            end
            S_T6:   next_state = Run ? S_T0 : S_IDLE;
`else
            S_T5:   next_state = Run ? S_T0 : S_IDLE;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Moore output decode from state and IR fields.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Cout     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        alu_op   = '0;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                // The incremented PC is loaded once; wait cycles only hold the read.
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = !t1_wait;
                Zlowout = !t1_wait;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Rout[rb] = 1'b1;
                Yin      = 1'b1;
            end
            S_T4: begin
                Zin    = 1'b1;
                alu_op = opc[OPCODE_WIDTH-2:0];
                if (imm_form) begin
                    Cout = 1'b1;
                end else begin
                    Rout[rc] = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                Rin[ra] = 1'b1;
            end
`ifdef ALU_SEQUENCER_WIDE_EN
            S_T6: begin
                Zhighout   = 1'b1;
                Rin[ra_hi] = 1'b1;
            end
`endif
            default: begin
                PCout = 1'b0;
            end
        endcase
    end

    assign Busy = (state != S_IDLE);
    assign Done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed, table-driven bench for alu_sequencer. Each table
//                record is one instruction with hand-computed strobe values
//                for T3..T6; hand-written sequences cover reset release,
//                back-to-back execution, return to IDLE and reset in T4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

`ifdef ALU_SEQUENCER_WIDE_EN
    localparam bit WIDE = 1'b1;
`else
    localparam bit WIDE = 1'b0;
`endif

    // Strobe vector order: PCout MARin IncPC PCin Read MDRin MDRout IRin
    //                      Yin Zin Zlowout Zhighout Cout
    localparam logic [12:0] ST_NONE = 13'b0_0000_0000_0000;
    localparam logic [12:0] ST_T0   = 13'b1_1100_0000_1000;
    localparam logic [12:0] ST_T1F  = 13'b0_0011_1000_0100;
    localparam logic [12:0] ST_T1W  = 13'b0_0001_1000_0000;
    localparam logic [12:0] ST_T2   = 13'b0_0000_0110_0000;
    localparam logic [12:0] ST_T3   = 13'b0_0000_0001_0000;
    localparam logic [12:0] ST_T4R  = 13'b0_0000_0000_1000;
    localparam logic [12:0] ST_T4I  = 13'b0_0000_0000_1001;
    localparam logic [12:0] ST_T5   = 13'b0_0000_0000_0100;
    localparam logic [12:0] ST_T6   = 13'b0_0000_0000_0010;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic        MemReady;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, Cout;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [3:0]  alu_op;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(
        .DATA_WIDTH   (32),
        .NUM_REGS     (16),
        .OPCODE_WIDTH (5)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .MemReady (MemReady),
        .IR       (IR),
        .PCout    (PCout),
        .MARin    (MARin),
        .IncPC    (IncPC),
        .PCin     (PCin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .Cout     (Cout),
        .Rin      (Rin),
        .Rout     (Rout),
        .alu_op   (alu_op),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ir;
        int          waits;
        logic [15:0] rout3;
        logic [15:0] rout4;
        logic        imm;
        logic [3:0]  op;
        logic [15:0] rin5;
        logic        wide;
        logic [15:0] rin6;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic expect_cycle(input string name, input logic [12:0] strb,
                                input logic [15:0] rin, input logic [15:0] rout,
                                input logic [3:0] op, input logic busy,
                                input logic done);
        logic [50:0] act;
        logic [50:0] exp;
        act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, Cout, Rin, Rout, alu_op, Busy, Done};
        exp = {strb, rin, rout, op, busy, done};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got strb=%b rin=%h rout=%h op=%h busy=%b done=%b, want strb=%b rin=%h rout=%h op=%h busy=%b done=%b",
                     name, act[50:38], act[37:22], act[21:6], act[5:2], act[1], act[0],
                     strb, rin, rout, op, busy, done);
        end
    endtask

    // Entered at a falling edge with the DUT in T0; leaves at the falling
    // edge of the cycle after the final state.
    task automatic run_vec(input vec_t v, input int idx, input logic prev_done,
                           input logic run_next);
        IR       = v.ir;
        Run      = 1'b0;
        MemReady = 1'b1;
        expect_cycle($sformatf("v%0d_T0", idx), ST_T0, 16'h0, 16'h0, 4'h0, 1'b1, prev_done);
        @(negedge Clock);
        for (int k = 0; k <= v.waits; k++) begin
            MemReady = (k == v.waits);
            expect_cycle($sformatf("v%0d_T1_%0d", idx, k), (k == 0) ? ST_T1F : ST_T1W,
                         16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
            @(negedge Clock);
        end
        MemReady = 1'b0;
        expect_cycle($sformatf("v%0d_T2", idx), ST_T2, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        @(negedge Clock);
        expect_cycle($sformatf("v%0d_T3", idx), ST_T3, 16'h0, v.rout3, 4'h0, 1'b1, 1'b0);
        @(negedge Clock);
        expect_cycle($sformatf("v%0d_T4", idx), v.imm ? ST_T4I : ST_T4R, 16'h0, v.rout4,
                     v.op, 1'b1, 1'b0);
        @(negedge Clock);
        Run = run_next;
        expect_cycle($sformatf("v%0d_T5", idx), ST_T5, v.rin5, 16'h0, 4'h0, 1'b1, 1'b0);
        @(negedge Clock);
        if (WIDE && v.wide) begin
            expect_cycle($sformatf("v%0d_T6", idx), ST_T6, v.rin6, 16'h0, 4'h0, 1'b1, 1'b0);
            @(negedge Clock);
        end
    endtask

    initial begin
        //               ir            waits rout3    rout4    imm  op    rin5     wide rin6
        vecs[0] = '{32'h2891_8000, 0, 16'h0004, 16'h0008, 1'b0, 4'h5, 16'h0002, 1'b0, 16'h0000};
        vecs[1] = '{32'h2891_8000, 3, 16'h0004, 16'h0008, 1'b0, 4'h5, 16'h0002, 1'b0, 16'h0000};
        vecs[2] = '{32'hA891_8000, 0, 16'h0004, 16'h0000, 1'b1, 4'h5, 16'h0002, 1'b0, 16'h0000};
        vecs[3] = '{32'h7791_8000, 1, 16'h0004, 16'h0008, 1'b0, 4'hE, 16'h8000, 1'b1, 16'h0001};
        vecs[4] = '{32'hF791_8000, 0, 16'h0004, 16'h0000, 1'b1, 4'hE, 16'h8000, 1'b0, 16'h0000};
        vecs[5] = '{32'h1BBB_8000, 0, 16'h0080, 16'h0080, 1'b0, 4'h3, 16'h0080, 1'b0, 16'h0000};
        vecs[6] = '{32'h7878_0000, 2, 16'h8000, 16'h0001, 1'b0, 4'hF, 16'h0001, 1'b1, 16'h0002};

        Resetn   = 1'b0;
        Run      = 1'b1;
        MemReady = 1'b0;
        IR       = vecs[0].ir;
        repeat (2) @(negedge Clock);
        expect_cycle("reset_state", ST_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);

        // Release reset mid-cycle with Run high: first edge must stay in IDLE.
        Resetn = 1'b1;
        @(negedge Clock);
        expect_cycle("release_first_edge", ST_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        @(negedge Clock);

        // Back-to-back instructions; the last one drops Run.
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i, (i != 0), (i != NV - 1));
        end
        expect_cycle("idle_done_pulse", ST_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        @(negedge Clock);
        expect_cycle("idle_hold", ST_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);

        // Reset asserted during T4.
        IR       = vecs[0].ir;
        Run      = 1'b1;
        MemReady = 1'b1;
        @(negedge Clock);
        expect_cycle("rst_seq_T0", ST_T0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        Run = 1'b0;
        repeat (4) @(negedge Clock);
        expect_cycle("rst_seq_T4", ST_T4R, 16'h0, 16'h0008, 4'h5, 1'b1, 1'b0);
        Resetn = 1'b0;
        #1;
        expect_cycle("rst_in_T4_immediate", ST_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            expect_cycle($sformatf("after_rst_%0d", k), ST_NONE, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
